// File: rtl/wb_sram_sp_adapter.sv
// Wishbone B3 slave front-end for a single-port plain-register SRAM macro.
// Handles classic cycles and linear/wrap bursts at one beat per clock. Out-of-range accesses are flagged with wb_err_o.
module wb_sram_sp_adapter #(
    parameter int unsigned AW       = 32,
    parameter int unsigned DW       = 32,
    parameter int unsigned MEM_SIZE = 32'h8000
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [AW-1:0]                wb_adr_i,
    input  logic [DW-1:0]                wb_dat_i,
    input  logic [DW/8-1:0]              wb_sel_i,
    input  logic                         wb_we_i,
    input  logic                         wb_cyc_i,
    input  logic                         wb_stb_i,
    input  logic [2:0]                   wb_cti_i,
    input  logic [1:0]                   wb_bte_i,
    output logic                         wb_ack_o,
    output logic                         wb_err_o,
    output logic                         wb_rty_o,
    output logic [DW-1:0]                wb_dat_o,
    output logic                         sram_ce,
    output logic                         sram_we,
    output logic                         sram_oe,
    output logic [AW-$clog2(DW/8)-1:0]   sram_addr,
    output logic [DW-1:0]                sram_din,
    output logic [DW/8-1:0]              sram_sel,
    input  logic [DW-1:0]                sram_dout
);

    localparam int unsigned SW        = DW / 8;
    localparam int unsigned OFS       = $clog2(SW);
    localparam int unsigned WAW       = AW - OFS;
    localparam int unsigned MEM_WORDS = MEM_SIZE / SW;
    localparam logic [WAW:0] LIM      = (WAW+1)'(MEM_WORDS);
    localparam logic [2:0] CTI_INCR   = 3'b010;

    typedef enum logic [1:0] {S_IDLE, S_ACK, S_BURST} state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [WAW-1:0]  r_nxt;
    logic [WAW-1:0]  w_nxt_d;
    logic [WAW-1:0]  r_addr;
    logic [WAW-1:0]  w_wadr;
    logic            w_oor;
    logic            w_last;
    logic            w_beat;
    logic            w_rd_ce;
    logic            w_unused;

    // Next word inside the burst: the wrap mask selects which low bits roll over.
    function automatic logic [WAW-1:0] f_inc(input logic [WAW-1:0] a, input logic [1:0] bte);
        logic [WAW-1:0] m;
        case (bte)
            2'b01:   m = WAW'(3);
            2'b10:   m = WAW'(7);
            2'b11:   m = WAW'(15);
            default: m = '1;
        endcase
        return (a & ~m) | ((a + WAW'(1)) & m);
    endfunction

    assign w_wadr   = wb_adr_i[AW-1:OFS];
    assign w_oor    = {1'b0, w_wadr} >= LIM;
    assign w_last   = (wb_cti_i != CTI_INCR);
    assign w_beat   = !rst && wb_cyc_i && wb_stb_i && (r_state == S_ACK || r_state == S_BURST);
    assign w_unused = ^wb_adr_i;

    assign wb_rty_o = 1'b0;
    assign sram_din = wb_dat_i;
    assign sram_sel = wb_sel_i;
    assign sram_ce  = sram_we | w_rd_ce;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_nxt   <= '0;
            r_addr  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_nxt   <= w_nxt_d;
            r_addr  <= sram_addr;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_nxt_d     = r_nxt;
        w_rd_ce     = 1'b0;
        wb_ack_o    = 1'b0;
        wb_err_o    = 1'b0;
        wb_dat_o    = '0;
        sram_we     = 1'b0;
        sram_oe     = 1'b0;
        sram_addr   = r_addr;

        if (rst) begin
            w_state_nxt = S_IDLE;
            w_nxt_d     = '0;
        end else if (!wb_cyc_i) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (wb_stb_i) begin
                        sram_addr   = w_wadr;
                        w_rd_ce     = 1'b1;
                        w_nxt_d     = f_inc(w_wadr, wb_bte_i);
                        w_state_nxt = (wb_cti_i == CTI_INCR) ? S_BURST : S_ACK;
                    end
                end
                S_ACK: begin
                    w_state_nxt = S_IDLE;
                end
                S_BURST: begin
                    if (wb_stb_i && !w_last) begin
                        w_nxt_d = f_inc(r_nxt, wb_bte_i);
                        // Read prefetch: present the following beat's address now.
                        if (!wb_we_i) begin
                            sram_addr = r_nxt;
                            w_rd_ce   = 1'b1;
                        end
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase

            // Data phase shared by classic ack and burst beats.
            if (w_beat) begin
                wb_ack_o = !w_oor;
                wb_err_o = w_oor;
                if (wb_we_i) begin
                    sram_we = !w_oor;
                    if (!w_oor) sram_addr = w_wadr;
                end else begin
                    sram_oe  = !w_oor;
                    wb_dat_o = w_oor ? '0 : sram_dout;
                end
            end
        end
    end

endmodule

// File: tb/tb_wb_sram_sp_adapter.sv
// Self-checking bench for wb_sram_sp_adapter: directed Wishbone sequences plus random traffic
// checked against a word-array reference memory.
module tb_wb_sram_sp_adapter;

    localparam int MW = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [3:0]  wb_sel_i;
    logic        wb_we_i;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic [2:0]  wb_cti_i;
    logic [1:0]  wb_bte_i;
    logic        wb_ack_o;
    logic        wb_err_o;
    logic        wb_rty_o;
    logic [31:0] wb_dat_o;
    logic        sram_ce;
    logic        sram_we;
    logic        sram_oe;
    logic [29:0] sram_addr;
    logic [31:0] sram_din;
    logic [3:0]  sram_sel;
    logic [31:0] sram_dout;

    int errors = 0;
    int checks = 0;

    logic [31:0] ref_mem  [0:MW-1];
    logic [31:0] sram_mem [0:MW-1];
    logic [29:0] sram_areg;
    logic [31:0] sram_tmp;
    logic        init_clr;

    always #5 clk = ~clk;

    wb_sram_sp_adapter #(.AW(32), .DW(32), .MEM_SIZE(32'h100)) dut (
        .clk(clk), .rst(rst),
        .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_sel_i(wb_sel_i), .wb_we_i(wb_we_i),
        .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_cti_i(wb_cti_i), .wb_bte_i(wb_bte_i),
        .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o), .wb_rty_o(wb_rty_o), .wb_dat_o(wb_dat_o),
        .sram_ce(sram_ce), .sram_we(sram_we), .sram_oe(sram_oe), .sram_addr(sram_addr),
        .sram_din(sram_din), .sram_sel(sram_sel), .sram_dout(sram_dout)
    );

    // SRAM macro: address registered on ce, dout combinational from the registered address.
    always @(posedge clk) begin
        if (init_clr) begin
            for (int i = 0; i < MW; i++) sram_mem[i] <= '0;
            sram_areg <= '0;
        end else if (sram_ce) begin
            if (sram_we && sram_addr < 30'(MW)) begin
                sram_tmp = sram_mem[sram_addr[5:0]];
                for (int b = 0; b < 4; b++)
                    if (sram_sel[b]) sram_tmp[8*b +: 8] = sram_din[8*b +: 8];
                sram_mem[sram_addr[5:0]] <= sram_tmp;
            end
            sram_areg <= sram_addr;
        end
    end
    assign sram_dout = (sram_areg < 30'(MW)) ? sram_mem[sram_areg[5:0]] : 32'h0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ref_write(input int w, input logic [31:0] d, input logic [3:0] s);
        for (int b = 0; b < 4; b++)
            if (s[b]) ref_mem[w][8*b +: 8] = d[8*b +: 8];
    endtask

    function automatic int next_word(input int w, input logic [1:0] bte);
        int n;
        int base;
        if (bte == 2'b00) return w + 1;
        n    = 4 << (int'(bte) - 1);
        base = (w / n) * n;
        return base + ((w - base + 1) % n);
    endfunction

    // Checks one acknowledged data phase against the reference and updates it for writes.
    task automatic check_beat(input string tag, input int w, input logic we, input logic [31:0] d,
                              input logic [3:0] s);
        logic oor;
        oor = (w >= MW);
        chk({tag, "_ack"}, 32'(wb_ack_o), 32'(!oor));
        chk({tag, "_err"}, 32'(wb_err_o), 32'(oor));
        chk({tag, "_we"},  32'(sram_we),  32'(we && !oor));
        chk({tag, "_dat"}, wb_dat_o, (!we && !oor) ? ref_mem[w] : 32'h0);
        if (we && !oor) ref_write(w, d, s);
    endtask

    task automatic classic(input logic we, input int w, input logic [31:0] d, input logic [3:0] s);
        tick();
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
        wb_adr_i = 32'(w * 4); wb_dat_i = d; wb_sel_i = s; wb_cti_i = 3'b000; wb_bte_i = 2'b00;
        @(negedge clk);
        chk("cl_req_ack", 32'(wb_ack_o | wb_err_o), 32'h0);
        chk("cl_req_ce", 32'(sram_ce), 32'h1);
        chk("cl_req_addr", 32'(sram_addr), 32'(w));
        tick();
        @(negedge clk);
        check_beat("cl", w, we, d, s);
        tick();
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        @(negedge clk);
        chk("cl_idle_ack", 32'(wb_ack_o | wb_err_o), 32'h0);
    endtask

    task automatic burst(input logic we, input int w0, input int len, input logic [1:0] bte,
                         input int abort_at);
        int w;
        w = w0;
        tick();
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
        wb_adr_i = 32'(w * 4); wb_cti_i = 3'b010; wb_bte_i = bte; wb_sel_i = 4'hF;
        @(negedge clk);
        chk("bu_addr_ack", 32'(wb_ack_o | wb_err_o), 32'h0);
        for (int i = 0; i < len; i++) begin
            if (i == abort_at) begin
                tick();
                wb_stb_i = 1'b0;
                @(negedge clk);
                chk("bu_abort_ack", 32'(wb_ack_o | wb_err_o), 32'h0);
                tick();
                wb_stb_i = 1'b1; wb_adr_i = 32'(w * 4); wb_cti_i = 3'b010;
                @(negedge clk);
                chk("bu_restart_ack", 32'(wb_ack_o | wb_err_o), 32'h0);
            end
            tick();
            wb_adr_i = 32'(w * 4);
            wb_dat_i = $urandom;
            wb_sel_i = we ? 4'($urandom_range(1, 15)) : 4'hF;
            wb_cti_i = (i == len - 1) ? 3'b111 : 3'b010;
            @(negedge clk);
            check_beat("bu", w, we, wb_dat_i, wb_sel_i);
            w = next_word(w, bte);
        end
        tick();
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        @(negedge clk);
        chk("bu_idle_ack", 32'(wb_ack_o | wb_err_o), 32'h0);
    endtask

    initial begin
        for (int i = 0; i < MW; i++) ref_mem[i] = '0;
        rst = 1'b1; init_clr = 1'b1;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1;
        wb_adr_i = 32'h10; wb_dat_i = 32'hDEADBEEF; wb_sel_i = 4'hF;
        wb_cti_i = 3'b000; wb_bte_i = 2'b00;
        repeat (3) begin
            @(negedge clk);
            chk("rst_ack", 32'(wb_ack_o), 32'h0);
            chk("rst_err", 32'(wb_err_o), 32'h0);
            chk("rst_we", 32'(sram_we), 32'h0);
            chk("rst_ce", 32'(sram_ce), 32'h0);
            chk("rst_dat", wb_dat_o, 32'h0);
        end
        chk("rty", 32'(wb_rty_o), 32'h0);
        tick();
        rst = 1'b0; init_clr = 1'b0; wb_cyc_i = 1'b0; wb_stb_i = 1'b0;

        classic(1'b1, 4, 32'hDEADBEEF, 4'hF);
        classic(1'b0, 4, 32'h0, 4'hF);
        classic(1'b1, 4, 32'h11223344, 4'b0100);
        classic(1'b0, 4, 32'h0, 4'hF);

        for (int i = 0; i < 4; i++) classic(1'b1, 8 + i, 32'hA0 + 32'(i), 4'hF);
        burst(1'b0, 8, 4, 2'b00, -1);

        burst(1'b1, 6, 4, 2'b01, -1);
        burst(1'b0, 6, 4, 2'b01, -1);
        burst(1'b0, 6, 4, 2'b01, 2);

        classic(1'b1, 64, 32'hCAFEF00D, 4'hF);
        classic(1'b0, 0, 32'h0, 4'hF);

        burst(1'b1, 62, 4, 2'b00, -1);
        burst(1'b0, 62, 4, 2'b00, -1);

        // Reset during the first beat of a write burst: no ack, no write.
        tick();
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1;
        wb_adr_i = 32'(20 * 4); wb_dat_i = 32'h55AA55AA; wb_sel_i = 4'hF;
        wb_cti_i = 3'b010; wb_bte_i = 2'b00;
        tick();
        rst = 1'b1;
        @(negedge clk);
        chk("rstmid_ack", 32'(wb_ack_o | wb_err_o), 32'h0);
        chk("rstmid_we", 32'(sram_we), 32'h0);
        tick();
        rst = 1'b0; wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        classic(1'b0, 20, 32'h0, 4'hF);

        for (int n = 0; n < 30; n++) begin
            logic rwe;
            int   len;
            int   ab;
            rwe = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 2) == 0) begin
                classic(rwe, $urandom_range(0, MW + 3), $urandom, 4'($urandom_range(1, 15)));
            end else begin
                len = $urandom_range(2, 8);
                ab  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, len - 1) : -1;
                burst(rwe, $urandom_range(0, MW + 2), len, 2'($urandom_range(0, 3)), ab);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/wb_sram_sp_adapter.md
# wb_sram_sp_adapter

Wishbone B3 slave front-end that drives the single-port plain-register SRAM macro (`ce`/`we`/`oe`/`addr`/`din`/`sel` in, `dout` out).
- Converts Wishbone byte addresses to SRAM word addresses.
- Handles the SRAM's one-cycle read latency (registered address, combinational `dout`).
- Supports classic cycles and incrementing bursts (linear and wrap-4/8/16) at one beat per clock.
- Flags out-of-range accesses with `wb_err_o`.

## Interface
Parameters:
- AW, 32, Wishbone byte-address width.
- DW, 32, data width; 32, 16 or 8. SW = DW/8 byte selects. OFS = log2(SW).
- MEM_SIZE, 'h8000, memory size in bytes. MEM_WORDS = MEM_SIZE/SW.

Ports (reset rst, synchronous, active-high; clock clk):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- wb_adr_i  in  AW  byte address
- wb_dat_i  in  DW  write data
- wb_sel_i  in  SW  byte selects
- wb_we_i  in  1  write enable
- wb_cyc_i  in  1  bus cycle valid
- wb_stb_i  in  1  strobe
- wb_cti_i  in  3  cycle type: 000 classic, 010 incrementing, 111 end-of-burst
- wb_bte_i  in  2  burst type: 00 linear, 01 wrap4, 10 wrap8, 11 wrap16
- wb_ack_o  out  1  transfer acknowledge
- wb_err_o  out  1  out-of-range error
- wb_rty_o  out  1  constant 0
- wb_dat_o  out  DW  read data; sram_dout when read acked, else 0
- sram_ce  out  1  chip enable
- sram_we  out  1  write enable
- sram_oe  out  1  output enable
- sram_addr  out  AW-OFS  word address
- sram_din  out  DW  = wb_dat_i
- sram_sel  out  SW  = wb_sel_i
- sram_dout  in  DW  SRAM read data; combinational from address registered at previous edge

## Operation
- States: IDLE, ACK, BURST.
- Word address: wadr = wb_adr_i[AW-1:OFS]. Out of range when wadr >= MEM_WORDS.
- IDLE, on `cyc&stb`:
  - Drive sram_addr = wadr, sram_ce = 1.
  - Go to BURST if cti = 010, else ACK.
  - Latch nxt = wadr incremented per bte.
    - Linear: plain +1.
    - Wrap-N: low log2(N) bits increment modulo N; upper bits held.
- ACK, one cycle:
  - Assert ack (or err if out of range).
  - Write: sram_we = 1 unless err.
  - Read: sram_oe = 1; wb_dat_o = sram_dout.
  - Then return to IDLE.
- BURST, each cycle with `cyc&stb`:
  - Acknowledge the current beat (ack or err).
  - Write: write the beat at wadr of the current wb_adr_i.
  - Read: return sram_dout; drive sram_addr = nxt (prefetch); advance nxt.
  - If cti = 111 or cti != 010, the beat is the last one: return to IDLE, no prefetch.
- Burst abort: stb = 0 in BURST drops ack and returns to IDLE; the next strobe restarts with an address cycle.
- cyc = 0 in any state returns to IDLE with no write.
- Errors:
  - err and ack are mutually exclusive.
  - A write with err never asserts sram_we.
  - A read with err returns wb_dat_o = 0.
- sram_ce = sram_we | (any cycle driving a read address).
- sram_addr holds its last value when idle.

## Timing
- Reset: state IDLE. wb_ack_o, wb_err_o, wb_rty_o, sram_we, sram_ce, sram_oe = 0; wb_dat_o = 0; nxt = 0.
- Classic read or write: request at cycle 0, ack at cycle 1, master free at cycle 2. Throughput is 1 access per 2 cycles.
- Burst of N beats: first ack at cycle 1, then one ack per cycle, last ack at cycle N. Total N+1 cycles.
- All outputs are decoded from registered state plus current inputs.
- No combinational path from wb_ack_o back into wb_stb_i.
- Wrap boundary: wrap4 starting at word 6 returns words 6, 7, 4, 5.
- Linear burst crossing MEM_WORDS: in-range beats get ack, out-of-range beats get err. Burst continues.
- rst asserted mid-burst: IDLE on the next edge, no ack that cycle, no partial write.

## Test plan
- Reset: hold rst 3 cycles with cyc = stb = 1 -> ack, err, sram_we stay 0; state IDLE.
- Classic write then read: write 0xDEADBEEF, sel = 1111 to 0x10; read 0x10 -> ack at cycle 1 each; read returns 0xDEADBEEF; sram_addr = 4.
- Byte select: write 0x11223344 sel = 0100 over 0xDEADBEEF at 0x10 -> read returns 0xDE22BEEF.
- Linear read burst of 4 from 0x20 (words preloaded 8..11 = 0xA0..0xA3) -> acks on 4 consecutive cycles, data 0xA0, 0xA1, 0xA2, 0xA3; cti = 111 on beat 4 -> IDLE.
- Wrap4 read burst from 0x18 -> word order 6, 7, 4, 5. Also stb dropped after beat 2 -> ack low, IDLE; re-strobe gives an address cycle, then correct data.
- Out of range: MEM_SIZE = 'h100, write to 0x100 -> err at cycle 1, no ack, sram_we = 0; memory at word 0 unchanged.
